// File: rtl/iob_eth_txq_sched_pkg.sv
// Shared definitions for the multi-queue TX BD scheduler: BD word0 bit positions,
// FSM state encodings and a queue-id width helper.
package iob_eth_txq_sched_pkg;

  localparam int BD_LEN_LSB = 16;
  localparam int BD_RD      = 15;
  localparam int BD_IRQ     = 14;
  localparam int BD_WR      = 13;
  localparam int BD_CRC     = 11;
  localparam int BD_ERR     = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_RD0   = 3'd2,
    S_RD1   = 3'd3,
    S_ISSUE = 3'd4,
    S_WAIT  = 3'd5,
    S_WB    = 3'd6
  } state_e;

  function automatic int qid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_eth_txq_sched_arb.sv
// Queue arbiter: round-robin from last grant + 1, or strict priority (q0 highest)
// when IOB_ETH_TXQ_PRIO_EN is defined.
module iob_eth_txq_arb
  import iob_eth_txq_sched_pkg::*;
#(
  parameter  int NUM_Q = 4,
  localparam int QID_W = qid_width(NUM_Q)
) (
  input  logic [NUM_Q-1:0] req_i,
  input  logic [QID_W-1:0] last_i,
  output logic [NUM_Q-1:0] gnt_o,
  output logic [QID_W-1:0] idx_o,
  output logic             vld_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    int                j;
    logic [QID_W-1:0]  jq;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    jq    = '0;
    for (int i = 0; i < NUM_Q; i++) begin
`ifdef IOB_ETH_TXQ_PRIO_EN
      j = i;
`else
      j = (int'(last_i) + 1 + i) % NUM_Q;
`endif
      jq = QID_W'(j);
      if (!vld_o && req_i[jq]) begin
        vld_o     = 1'b1;
        gnt_o[jq] = 1'b1;
        idx_o     = jq;
      end
    end
  end

endmodule

// File: rtl/iob_eth_txq_sched.sv
// Multi-queue TX buffer-descriptor scheduler: doorbell counting, BD fetch, DMA issue,
// status write-back and per-queue IRQ. Optional macro: IOB_ETH_TXQ_PRIO_EN (strict priority).
module iob_eth_txq_sched
  import iob_eth_txq_sched_pkg::*;
#(
  parameter  int NUM_Q     = 4,
  parameter  int RING_LOG2 = 4,
  localparam int QID_W     = qid_width(NUM_Q),
  localparam int BD_ADDR_W = QID_W + RING_LOG2 + 1,
  localparam int CNT_W     = RING_LOG2 + 1
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic                       cke_i,
  input  logic [NUM_Q-1:0]           q_en_i,
  input  logic [NUM_Q-1:0]           doorbell_i,
  input  logic [NUM_Q-1:0]           ovf_clr_i,
  output logic [NUM_Q*CNT_W-1:0]     pending_o,
  output logic [NUM_Q*RING_LOG2-1:0] head_o,
  output logic [NUM_Q-1:0]           ovf_o,
  output logic [NUM_Q-1:0]           bd_err_o,
  output logic                       bd_en_o,
  output logic                       bd_wen_o,
  output logic [BD_ADDR_W-1:0]       bd_addr_o,
  output logic [31:0]                bd_wdata_o,
  input  logic [31:0]                bd_rdata_i,
  output logic                       dma_valid_o,
  input  logic                       dma_ready_i,
  output logic [15:0]                dma_len_o,
  output logic [31:0]                dma_ptr_o,
  output logic                       dma_crc_o,
  output logic [QID_W-1:0]           dma_qid_o,
  input  logic                       dma_done_i,
  input  logic                       dma_err_i,
  output logic [NUM_Q-1:0]           irq_o,
  output logic                       busy_o
);

  localparam logic [CNT_W-1:0]     RING_FULL = CNT_W'(1 << RING_LOG2);
  localparam logic [RING_LOG2-1:0] HEAD_MAX  = '1;

  state_e               state_q;
  logic [QID_W-1:0]     qid_q, last_q;
  logic [31:0]          w0_q, w1_q;
  logic                 err_q, dma_valid_q;
  logic [NUM_Q-1:0]     ovf_q, bd_err_q, irq_q;
  logic [CNT_W-1:0]     pending_q [NUM_Q];
  logic [RING_LOG2-1:0] head_q    [NUM_Q];

  logic [NUM_Q-1:0]     elig, arb_gnt;
  logic [QID_W-1:0]     arb_idx;
  logic                 arb_vld, cmpl;
  logic [RING_LOG2-1:0] arb_head;
  logic [31:0]          wb_word;

  always_comb begin
    elig      = '0;
    pending_o = '0;
    head_o    = '0;
    arb_head  = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      elig[q] = q_en_i[q] && (pending_q[q] != '0);
      pending_o[q*CNT_W +: CNT_W]         = pending_q[q];
      head_o[q*RING_LOG2 +: RING_LOG2]    = head_q[q];
      if (arb_gnt[q]) arb_head = arb_head | head_q[q];
    end
  end

  iob_eth_txq_arb #(.NUM_Q(NUM_Q)) u_arb (
    .req_i  (elig),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  // A BD retires either when it was fetched without ownership or after write-back.
  assign cmpl = (state_q == S_RD1 && !w0_q[BD_RD]) || (state_q == S_WB);

  always_comb begin
    wb_word         = w0_q;
    wb_word[BD_RD]  = 1'b0;
    wb_word[BD_ERR] = err_q;
  end

  always_comb begin
    bd_en_o    = 1'b0;
    bd_wen_o   = 1'b0;
    bd_wdata_o = '0;
    bd_addr_o  = {qid_q, head_q[qid_q], 1'b0};
    case (state_q)
      S_ARB: begin
        bd_en_o   = arb_vld;
        bd_addr_o = {arb_idx, arb_head, 1'b0};
      end
      S_RD0: begin
        bd_en_o      = 1'b1;
        bd_addr_o[0] = 1'b1;
      end
      S_WB: begin
        bd_en_o    = 1'b1;
        bd_wen_o   = 1'b1;
        bd_wdata_o = wb_word;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      qid_q       <= '0;
      last_q      <= QID_W'(NUM_Q - 1);
      w0_q        <= '0;
      w1_q        <= '0;
      err_q       <= 1'b0;
      dma_valid_q <= 1'b0;
      ovf_q       <= '0;
      bd_err_q    <= '0;
      irq_q       <= '0;
      // NOTE: these arrays are a few flops per queue, not RAM, so they take the
      // async reset; the BD rings themselves live in the external BD RAM.
      for (int q = 0; q < NUM_Q; q++) begin
        pending_q[q] <= '0;
        head_q[q]    <= '0;
      end
    end else if (cke_i) begin
      irq_q <= '0;
      for (int q = 0; q < NUM_Q; q++) begin
        logic full, acc, dec;
        full = (pending_q[q] == RING_FULL);
        acc  = doorbell_i[q] && !full;
        dec  = cmpl && (qid_q == QID_W'(q));
        if (doorbell_i[q] && full) ovf_q[q] <= 1'b1;
        else if (ovf_clr_i[q])     ovf_q[q] <= 1'b0;
        if (ovf_clr_i[q]) bd_err_q[q] <= 1'b0;
        if (acc && !dec)      pending_q[q] <= pending_q[q] + 1'b1;
        else if (!acc && dec) pending_q[q] <= pending_q[q] - 1'b1;
      end

      case (state_q)
        S_IDLE: if (|elig) state_q <= S_ARB;
        S_ARB: begin
          if (arb_vld) begin
            qid_q   <= arb_idx;
            last_q  <= arb_idx;
            state_q <= S_RD0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD0: begin
          w0_q    <= bd_rdata_i;
          state_q <= S_RD1;
        end
        S_RD1: begin
          w1_q <= bd_rdata_i;
          if (!w0_q[BD_RD]) begin
            bd_err_q[qid_q] <= 1'b1;
            state_q         <= S_IDLE;
          end else begin
            dma_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dma_ready_i) begin
            dma_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dma_done_i) begin
            err_q   <= dma_err_i;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (w0_q[BD_WR] || head_q[qid_q] == HEAD_MAX) head_q[qid_q] <= '0;
          else                                          head_q[qid_q] <= head_q[qid_q] + 1'b1;
          irq_q[qid_q] <= w0_q[BD_IRQ];
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ovf_o       = ovf_q;
  assign bd_err_o    = bd_err_q;
  assign irq_o       = irq_q;
  assign dma_valid_o = dma_valid_q;
  assign dma_len_o   = w0_q[BD_LEN_LSB +: 16];
  assign dma_ptr_o   = w1_q;
  assign dma_crc_o   = w0_q[BD_CRC];
  assign dma_qid_o   = qid_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_iob_eth_txq_sched.sv
// Directed self-checking bench for iob_eth_txq_sched (NUM_Q=4, RING_LOG2=4) with a
// behavioural BD RAM and a hand-driven DMA side.
module tb_iob_eth_txq_sched;

  localparam int NUM_Q = 4, RING_LOG2 = 4, CNT_W = 5, QID_W = 2, BD_ADDR_W = 7;

  logic clk = 1'b0;
  logic arst_n, cke;
  logic [NUM_Q-1:0] q_en, doorbell, ovf_clr;
  logic [NUM_Q*CNT_W-1:0] pending_o;
  logic [NUM_Q*RING_LOG2-1:0] head_o;
  logic [NUM_Q-1:0] ovf_o, bd_err_o, irq_o;
  logic bd_en_o, bd_wen_o;
  logic [BD_ADDR_W-1:0] bd_addr_o;
  logic [31:0] bd_wdata_o, bd_rdata;
  logic dma_valid_o, dma_ready, dma_crc_o, dma_done, dma_err, busy_o;
  logic [15:0] dma_len_o;
  logic [31:0] dma_ptr_o;
  logic [QID_W-1:0] dma_qid_o;

  logic [31:0] mem [128];
  logic tb_we;
  logic [6:0] tb_addr;
  logic [31:0] tb_data;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iob_eth_txq_sched #(.NUM_Q(NUM_Q), .RING_LOG2(RING_LOG2)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .q_en_i(q_en),
    .doorbell_i(doorbell), .ovf_clr_i(ovf_clr), .pending_o(pending_o),
    .head_o(head_o), .ovf_o(ovf_o), .bd_err_o(bd_err_o), .bd_en_o(bd_en_o),
    .bd_wen_o(bd_wen_o), .bd_addr_o(bd_addr_o), .bd_wdata_o(bd_wdata_o),
    .bd_rdata_i(bd_rdata), .dma_valid_o(dma_valid_o), .dma_ready_i(dma_ready),
    .dma_len_o(dma_len_o), .dma_ptr_o(dma_ptr_o), .dma_crc_o(dma_crc_o),
    .dma_qid_o(dma_qid_o), .dma_done_i(dma_done), .dma_err_i(dma_err),
    .irq_o(irq_o), .busy_o(busy_o)
  );

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (bd_en_o) begin
      if (bd_wen_o) mem[bd_addr_o] <= bd_wdata_o;
      else          bd_rdata <= mem[bd_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ba(input int q, input int idx, input int w);
    return q * 32 + idx * 2 + w;
  endfunction

  function automatic logic [31:0] mk_w0(input int len, input bit rd, input bit irq,
                                        input bit wr, input bit crc);
    logic [15:0] l;
    l = 16'(len);
    return {l, rd, irq, wr, 1'b0, crc, 11'b0};
  endfunction

  function automatic logic [31:0] pend(input int q);
    return 32'(pending_o[q*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [31:0] head(input int q);
    return 32'(head_o[q*RING_LOG2 +: RING_LOG2]);
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    tb_we = 1'b1; tb_addr = 7'(a); tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic set_bd(input int q, input int idx, input logic [31:0] w0, input logic [31:0] ptr);
    poke(ba(q, idx, 0), w0);
    poke(ba(q, idx, 1), ptr);
  endtask

  task automatic ring(input logic [NUM_Q-1:0] m);
    doorbell = m;
    @(negedge clk);
    doorbell = '0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0; cke = 1'b1; q_en = '1; doorbell = '0; ovf_clr = '0;
    dma_ready = 1'b0; dma_done = 1'b0; dma_err = 1'b0; tb_we = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!dma_valid_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("dma_valid seen", 32'(dma_valid_o), 1);
  endtask

  task automatic serve(input int q, input int len, input logic [31:0] ptr, input bit crc,
                       input bit err, output logic [NUM_Q-1:0] irq_seen);
    wait_valid();
    check("dma_qid", 32'(dma_qid_o), 32'(q));
    check("dma_len", 32'(dma_len_o), 32'(len));
    check("dma_ptr", dma_ptr_o, ptr);
    check("dma_crc", 32'(dma_crc_o), 32'(crc));
    dma_ready = 1'b1;
    @(negedge clk);
    dma_ready = 1'b0;
    repeat (2) @(negedge clk);
    dma_done = 1'b1; dma_err = err;
    @(negedge clk);
    dma_done = 1'b0; dma_err = 1'b0;
    @(negedge clk);
    irq_seen = irq_o;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_Q-1:0] irq;
    int exp_order[5];
    int served[NUM_Q];
    bit saw_valid;

    do_reset();
    check("rst pending", 32'(pending_o), 0);
    check("rst head", 32'(head_o), 0);
    check("rst busy", 32'(busy_o), 0);
    check("rst dma_valid", 32'(dma_valid_o), 0);
    check("rst ovf/err/irq", {20'b0, ovf_o, bd_err_o, irq_o}, 0);
    check("rst bd_en", 32'(bd_en_o), 0);

    // Single BD on q0: latency, fields, write-back, IRQ.
    set_bd(0, 0, mk_w0(64, 1, 1, 0, 1), 32'h1000);
    ring(4'b0001);
    repeat (3) @(negedge clk);
    check("lat valid at 3", 32'(dma_valid_o), 0);
    @(negedge clk);
    check("lat valid at 4", 32'(dma_valid_o), 1);
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    check("done outside WAIT ignored", 32'(dma_valid_o), 1);
    serve(0, 64, 32'h1000, 1, 0, irq);
    check("t1 irq", 32'(irq), 32'h1);
    check("t1 wb word0", mem[ba(0, 0, 0)], 32'h0040_4800);
    check("t1 head0", head(0), 1);
    check("t1 pend0", pend(0), 0);
    @(negedge clk);
    check("t1 irq 1 cycle", 32'(irq_o), 0);

    // Arbitration order with q0 refilled while its first frame is in flight.
    do_reset();
    for (int q = 0; q < NUM_Q; q++) set_bd(q, 0, mk_w0(100 + q, 1, 0, 0, 0), 32'h2000 + q * 256);
    set_bd(0, 1, mk_w0(200, 1, 0, 0, 0), 32'h3000);
`ifdef IOB_ETH_TXQ_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int q = 0; q < NUM_Q; q++) served[q] = 0;
    ring(4'hF);
    wait_valid();
    ring(4'b0001);
    for (int k = 0; k < 5; k++) begin
      int q, idx;
      q = exp_order[k];
      idx = served[q];
      serve(q, 100 + q + 100 * idx, 32'h2000 + q * 256 + idx * 4096, 0, 0, irq);
      served[q]++;
    end
    check("t2 heads", 32'(head_o), 32'h1112);
    check("t2 pending", 32'(pending_o), 0);

    // Ring wrap at idx 15 on q3.
    do_reset();
    for (int i = 0; i < 16; i++) set_bd(3, i, mk_w0(10 + i, 1, 0, 0, 0), 32'h4000 + i);
    for (int i = 0; i < 16; i++) ring(4'b1000);
    check("t3 no ovf", 32'(ovf_o), 0);
    for (int i = 0; i < 16; i++) begin
      serve(3, 10 + i, 32'h4000 + i, 0, 0, irq);
      if (i == 14) check("t3 head3 at 15", head(3), 15);
    end
    check("t3 head3 wrapped", head(3), 0);
    check("t3 pend3", pend(3), 0);

    // WR bit at idx 3 on q1 forces the head back to 0.
    for (int i = 0; i < 4; i++) set_bd(1, i, mk_w0(20 + i, 1, 0, i == 3, 0), 32'h4100 + i);
    for (int i = 0; i < 4; i++) ring(4'b0010);
    for (int i = 0; i < 4; i++) serve(1, 20 + i, 32'h4100 + i, 0, 0, irq);
    check("t3 head1 WR wrap", head(1), 0);

    // Overflow on a disabled queue.
    do_reset();
    q_en = 4'b1101;
    for (int i = 0; i < 16; i++) ring(4'b0010);
    check("t4 pend1 full", pend(1), 16);
    check("t4 ovf before", 32'(ovf_o), 0);
    ring(4'b0010);
    check("t4 ovf set", 32'(ovf_o), 32'h2);
    check("t4 pend1 held", pend(1), 16);
    check("t4 not busy", 32'(busy_o), 0);
    ovf_clr = 4'b0010;
    @(negedge clk);
    ovf_clr = '0;
    check("t4 ovf cleared", 32'(ovf_o), 0);

    // BD not owned by hardware, then an errored completion.
    do_reset();
    set_bd(2, 0, mk_w0(64, 0, 0, 0, 0), 32'h6000);
    ring(4'b0100);
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_valid |= dma_valid_o;
    end
    check("t5 no dma_valid", 32'(saw_valid), 0);
    check("t5 bd_err", 32'(bd_err_o), 32'h4);
    check("t5 pend2", pend(2), 0);
    check("t5 head2", head(2), 0);
    ovf_clr = 4'b0100;
    @(negedge clk);
    ovf_clr = '0;
    check("t5 bd_err cleared", 32'(bd_err_o), 0);
    set_bd(2, 0, mk_w0(128, 1, 0, 0, 1), 32'h6100);
    ring(4'b0100);
    serve(2, 128, 32'h6100, 1, 1, irq);
    check("t5 no irq", 32'(irq), 0);
    check("t5 ERR written", mem[ba(2, 0, 0)], 32'h0080_0900);
    check("t5 head2 adv", head(2), 1);

    // Asynchronous reset while waiting for completion.
    do_reset();
    set_bd(0, 0, mk_w0(64, 1, 1, 0, 1), 32'h5000);
    ring(4'b0001);
    wait_valid();
    dma_ready = 1'b1;
    @(negedge clk);
    dma_ready = 1'b0;
    @(negedge clk);
    check("t6 in WAIT busy", 32'(busy_o), 1);
    #1 arst_n = 1'b0;
    #1;
    check("t6 rst busy", 32'(busy_o), 0);
    check("t6 rst pending", 32'(pending_o), 0);
    check("t6 rst dma", {dma_len_o, 15'b0, dma_valid_o}, 0);
    check("t6 rst ptr", dma_ptr_o, 0);
    check("t6 rst bd_en", 32'(bd_en_o), 0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Clock enable low for 5 cycles in ISSUE freezes everything.
    ring(4'b0001);
    wait_valid();
    cke = 1'b0;
    dma_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      doorbell = (i == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      check("t6 cke hold valid", 32'(dma_valid_o), 1);
    end
    doorbell = '0;
    check("t6 cke pend1", pend(1), 0);
    check("t6 cke pend0", pend(0), 1);
    dma_ready = 1'b0;
    cke = 1'b1;
    serve(0, 64, 32'h5000, 1, 0, irq);
    check("t6 irq", 32'(irq), 32'h1);
    check("t6 head0", head(0), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
